// File: rtl/kamikaze_hazard_ctrl_pkg.sv
// kamikaze_hazard_ctrl_pkg: shared types and constants for the issue hazard controller
package kamikaze_hazard_ctrl_pkg;
  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;
  typedef enum logic {HZ_RUN = 1'b0, HZ_DRAIN = 1'b1} hz_state_e;
  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             we;
  } entry_t;
endpackage

// File: rtl/kamikaze_inflight_fifo.sv
// kamikaze_inflight_fifo: circular buffer of in-flight {rd, we} entries, all slots exposed for parallel compare
module kamikaze_inflight_fifo
  import kamikaze_hazard_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  entry_t                 push_entry_i,
  input  logic                   pop_i,
  output entry_t [DEPTH-1:0]     entries_o,
  output logic   [DEPTH-1:0]     valid_o,
  output logic   [DEPTH-1:0]     head_mask_o,
  output logic   [REG_W-1:0]     head_rd_o,
  output logic   [PW:0]          count_o
);
  entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0] count_q, count_d;
  always_comb begin
    mem_d = mem_q;
    if (push_i) mem_d[wr_q] = push_entry_i;
  end
  assign wr_d    = wr_q + PW'(push_i);
  assign rd_d    = rd_q + PW'(pop_i);
  assign count_d = count_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end
  // slot age relative to head decides validity; pointer wrap keeps the offset modulo DEPTH
  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    logic [PW-1:0] off;
    assign off            = PW'(g) - rd_q;
    assign valid_o[g]     = {1'b0, off} < count_q;
    assign head_mask_o[g] = rd_q == PW'(g);
  end
  assign entries_o = mem_q;
  assign head_rd_o = mem_q[rd_q].rd;
  assign count_o   = count_q;
endmodule

// File: rtl/kamikaze_hazard_ctrl.sv
// kamikaze_hazard_ctrl: in-order issue controller with RAW/full stalls and flush drain
// Define KAMIKAZE_HAZARD_BYPASS_EN to let a dependent issue in its producer's writeback cycle.
module kamikaze_hazard_ctrl
  import kamikaze_hazard_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     issue_valid_i,
  input  logic [REG_W-1:0]         issue_rs1_i,
  input  logic [REG_W-1:0]         issue_rs2_i,
  input  logic                     issue_rs1_used_i,
  input  logic                     issue_rs2_used_i,
  input  logic [REG_W-1:0]         issue_rd_i,
  input  logic                     issue_rd_we_i,
  output logic                     issue_ready_o,
  input  logic                     wb_valid_i,
  input  logic                     wb_we_i,
  input  logic [REG_W-1:0]         wb_rd_i,
  input  logic                     flush_i,
  output logic                     kill_o,
  output logic [$clog2(DEPTH):0]   inflight_o,
  output logic                     err_o
);
  localparam int CW = $clog2(DEPTH) + 1;
`ifdef KAMIKAZE_HAZARD_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif
  hz_state_e state_q, state_d;
  logic err_q, err_d;
  entry_t [DEPTH-1:0] ent;
  logic [DEPTH-1:0] vld, head_m, m1, m2, m1_eff, m2_eff;
  logic [REG_W-1:0] head_rd;
  logic [CW-1:0] cnt;
  logic ret1, ret2, haz1, haz2, full, push, pop, empty, next_empty;
  kamikaze_inflight_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .push_entry_i('{rd: issue_rd_i, we: issue_rd_we_i && issue_rd_i != REG_ZERO}),
    .pop_i       (pop),
    .entries_o   (ent),
    .valid_o     (vld),
    .head_mask_o (head_m),
    .head_rd_o   (head_rd),
    .count_o     (cnt)
  );
  for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
    assign m1[g] = vld[g] & ent[g].we & (ent[g].rd == issue_rs1_i);
    assign m2[g] = vld[g] & ent[g].we & (ent[g].rd == issue_rs2_i);
  end
  assign ret1 = wb_valid_i & wb_we_i & (wb_rd_i == issue_rs1_i);
  assign ret2 = wb_valid_i & wb_we_i & (wb_rd_i == issue_rs2_i);
  // only the retiring head is forgiven; any younger match still stalls
  assign m1_eff = m1 & ~(head_m & {DEPTH{BYP & ret1}});
  assign m2_eff = m2 & ~(head_m & {DEPTH{BYP & ret2}});
  assign haz1 = issue_rs1_used_i & (issue_rs1_i != REG_ZERO) & |m1_eff;
  assign haz2 = issue_rs2_used_i & (issue_rs2_i != REG_ZERO) & |m2_eff;
  assign full       = cnt == CW'(DEPTH);
  assign empty      = cnt == '0;
  assign next_empty = empty | (cnt == CW'(1) & wb_valid_i);
  assign issue_ready_o = (state_q == HZ_RUN) & ~full & ~haz1 & ~haz2 & ~flush_i;
  assign push = issue_valid_i & issue_ready_o;
  assign pop  = wb_valid_i & ~empty;
  always_comb begin
    state_d = state_q == HZ_RUN ? (flush_i ? HZ_DRAIN : HZ_RUN) : (next_empty ? HZ_RUN : HZ_DRAIN);
    err_d   = err_q | (wb_valid_i & (empty | (wb_we_i & (wb_rd_i != head_rd))));
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= HZ_RUN;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end
  assign kill_o     = state_q == HZ_DRAIN;
  assign inflight_o = cnt;
  assign err_o      = err_q;
endmodule
